// File: rtl/clk_ratio_meter.sv
// ---------------------------------------------------------------------------
// clk_ratio_meter
//
// Measures a slow periodic signal (typically a divided clock) against the
// reference clock. Reports the rise-to-rise period and the rise-to-fall high
// time in reference cycles. Declares lock once the same (period, high_time)
// pair has been seen LOCK_CNT times in a row. Flags loss when the expected
// edge does not arrive within TIMEOUT cycles of the last rise.
//
// Parameters
//   W         counter / measurement width
//   TIMEOUT   cycles after the last rise with no expected edge -> sig_lost
//   LOCK_CNT  consecutive identical measurements needed for locked
//
// Ports
//   clk_in      in   reference clock, all logic on posedge
//   rst_n       in   asynchronous active-low reset
//   sig_in      in   signal under measurement, asynchronous to clk_in
//   period      out  last measured rise-to-rise distance (cycles)
//   high_time   out  last measured rise-to-fall distance (cycles)
//   meas_valid  out  one-cycle pulse when period/high_time update
//   duty_ok     out  2*high_time within +/-1 of period
//   locked      out  LOCK_CNT consecutive identical measurements
//   sig_lost    out  expected edge missing for TIMEOUT cycles
// ---------------------------------------------------------------------------
module clk_ratio_meter #(
    parameter int W        = 10,
    parameter int TIMEOUT  = 1023,
    parameter int LOCK_CNT = 4
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         meas_valid,
    output logic         duty_ok,
    output logic         locked,
    output logic         sig_lost
);

    localparam int MW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t        state;
    logic          sig_meta;
    logic          sig_s;
    logic          sig_d;
    logic [W-1:0]  cnt;
    logic [W-1:0]  hi_cap;
    logic [MW-1:0] match_cnt;
    logic          first_meas;

    logic          rise;
    logic          fall;
    logic          timeout_hit;
    logic          same_pair;
    logic [MW-1:0] match_next;
    logic [W:0]    twice_hi;
    logic [W:0]    p_ext;
    logic          duty_calc;

    assign rise        = sig_s & ~sig_d;
    assign fall        = ~sig_s & sig_d;
    assign timeout_hit = (cnt == W'(TIMEOUT));

    // In LOW, a rise closes a measurement: cnt is the new period and hi_cap
    // the new high time. These are compared against the currently reported
    // pair, which is the previous measurement.
    assign same_pair = (cnt == period) && (hi_cap == high_time);

    always_comb begin
        match_next = MW'(1);
        if (!first_meas && same_pair) begin
            if (match_cnt == MW'(LOCK_CNT))
                match_next = match_cnt;
            else
                match_next = match_cnt + MW'(1);
        end
    end

    // Duty check done one bit wider so 2*high_time cannot wrap.
    assign twice_hi  = {hi_cap, 1'b0};
    assign p_ext     = {1'b0, cnt};
    assign duty_calc = (twice_hi == p_ext)
                    || ((twice_hi + (W+1)'(1)) == p_ext)
                    || (twice_hi == (p_ext + (W+1)'(1)));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sig_meta   <= 1'b0;
            sig_s      <= 1'b0;
            sig_d      <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            hi_cap     <= '0;
            match_cnt  <= '0;
            first_meas <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            duty_ok    <= 1'b0;
            locked     <= 1'b0;
            sig_lost   <= 1'b0;
        end else begin
            sig_meta   <= sig_in;
            sig_s      <= sig_meta;
            sig_d      <= sig_s;
            meas_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state      <= HIGH;
                        cnt        <= W'(1);
                        sig_lost   <= 1'b0;
                        // The first pair after IDLE has nothing valid to
                        // compare against.
                        first_meas <= 1'b1;
                    end
                end

                HIGH: begin
                    // An edge in the same cycle as the timeout wins.
                    if (fall) begin
                        hi_cap <= cnt;
                        cnt    <= cnt + W'(1);
                        state  <= LOW;
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        sig_lost  <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        duty_ok   <= 1'b0;
                    end else begin
                        cnt <= cnt + W'(1);
                    end
                end

                LOW: begin
                    if (rise) begin
                        period     <= cnt;
                        high_time  <= hi_cap;
                        meas_valid <= 1'b1;
                        duty_ok    <= duty_calc;
                        match_cnt  <= match_next;
                        locked     <= (match_next == MW'(LOCK_CNT));
                        first_meas <= 1'b0;
                        cnt        <= W'(1);
                        state      <= HIGH;
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        sig_lost  <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        duty_ok   <= 1'b0;
                    end else begin
                        cnt <= cnt + W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_ratio_meter.sv
`timescale 1ns/1ps
module tb_clk_ratio_meter;

    localparam int W        = 10;
    localparam int TIMEOUT  = 20;
    localparam int LOCK_CNT = 4;

    logic         clk_in;
    logic         rst_n;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         meas_valid;
    logic         duty_ok;
    logic         locked;
    logic         sig_lost;

    clk_ratio_meter #(
        .W       (W),
        .TIMEOUT (TIMEOUT),
        .LOCK_CNT(LOCK_CNT)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .duty_ok   (duty_ok),
        .locked    (locked),
        .sig_lost  (sig_lost)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [W-1:0] p;
        logic [W-1:0] h;
        logic         d;
        logic         l;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_valid = 0;
    int last_valid_cyc = 0;
    bit gap_armed = 0;

    // Reference model of lock behaviour and pending measurement.
    bit have_rise = 0;
    int pend_p = 0;
    int pend_h = 0;
    bit m_first = 1;
    int m_cnt = 0;
    int m_prev_p = 0;
    int m_prev_h = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Output monitor: pops one expectation per meas_valid pulse.
    always @(negedge clk_in) begin
        if (rst_n && meas_valid) begin
            n_valid = n_valid + 1;
            if (sb.size() == 0) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL unexpected_valid: got period=%0d high=%0d, required no pulse", period, high_time);
            end else begin
                mon_e = sb.pop_front();
                $display("valid #%0d @cyc %0d: period=%0d high=%0d duty_ok=%0b locked=%0b",
                         n_valid, cyc, period, high_time, duty_ok, locked);
                total = total + 1;
                if (period !== mon_e.p) begin
                    bad = bad + 1;
                    $display("FAIL period: got %0d required %0d", period, mon_e.p);
                end
                total = total + 1;
                if (high_time !== mon_e.h) begin
                    bad = bad + 1;
                    $display("FAIL high_time: got %0d required %0d", high_time, mon_e.h);
                end
                total = total + 1;
                if (duty_ok !== mon_e.d) begin
                    bad = bad + 1;
                    $display("FAIL duty_ok: got %0b required %0b", duty_ok, mon_e.d);
                end
                total = total + 1;
                if (locked !== mon_e.l) begin
                    bad = bad + 1;
                    $display("FAIL locked: got %0b required %0b", locked, mon_e.l);
                end
                if (gap_armed) begin
                    total = total + 1;
                    if ((cyc - last_valid_cyc) != int'(mon_e.p)) begin
                        bad = bad + 1;
                        $display("FAIL valid_gap: got %0d required %0d", cyc - last_valid_cyc, mon_e.p);
                    end
                end
            end
            gap_armed = 1;
            last_valid_cyc = cyc;
        end
    end

    task automatic push_exp(input int p, input int h);
        exp_t e;
        if (m_first || p != m_prev_p || h != m_prev_h)
            m_cnt = 1;
        else if (m_cnt < LOCK_CNT)
            m_cnt = m_cnt + 1;
        m_first  = 0;
        m_prev_p = p;
        m_prev_h = h;
        e.p = W'(p);
        e.h = W'(h);
        e.d = ((2 * h) >= (p - 1)) && ((2 * h) <= (p + 1));
        e.l = (m_cnt == LOCK_CNT);
        sb.push_back(e);
    endtask

    task automatic model_clear();
        have_rise = 0;
        m_first   = 1;
        m_cnt     = 0;
        gap_armed = 0;
        sb.delete();
    endtask

    // Raises sig_in; the previous complete period becomes a measurement.
    task automatic rise_edge(input int h, input int l);
        if (have_rise) push_exp(pend_p, pend_h);
        have_rise = 1;
        pend_h = h;
        pend_p = h + l;
        sig_in = 1'b1;
    endtask

    task automatic drive_period(input int h, input int l);
        rise_edge(h, l);
        repeat (h) @(posedge clk_in);
        #1 sig_in = 1'b0;
        repeat (l) @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        sig_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        model_clear();
        rst_n = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
    endtask

    task automatic finish_check(input string name);
        repeat (8) @(posedge clk_in);
        #1;
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL %s_missing_valids: got %0d outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sig_in = 1'b0;
        #2;
        total = total + 1;
        if ({period, high_time, meas_valid, duty_ok, locked, sig_lost} !== '0) begin
            bad = bad + 1;
            $display("FAIL reset_outputs: got p=%0d h=%0d v=%0b d=%0b l=%0b s=%0b, required all 0",
                     period, high_time, meas_valid, duty_ok, locked, sig_lost);
        end
        apply_reset();
        repeat (10) @(posedge clk_in);
        #1;
        total = total + 1;
        if ({meas_valid, sig_lost, locked} !== 3'b000) begin
            bad = bad + 1;
            $display("FAIL idle_quiet: got v=%0b s=%0b l=%0b, required 0 0 0", meas_valid, sig_lost, locked);
        end
    endtask

    task automatic test_div3();
        apply_reset();
        repeat (6) drive_period(2, 1);
        finish_check("div3");
    endtask

    task automatic test_div8();
        apply_reset();
        repeat (5) drive_period(4, 4);
        repeat (5) drive_period(2, 6);
        finish_check("div8");
    endtask

    task automatic test_toggle();
        apply_reset();
        repeat (6) drive_period(1, 1);
        finish_check("toggle");
    endtask

    task automatic test_ratio_change();
        apply_reset();
        repeat (5) drive_period(3, 2);
        repeat (5) drive_period(4, 3);
        finish_check("ratio_change");
    endtask

    task automatic test_timeout();
        apply_reset();
        repeat (5) drive_period(3, 2);
        total = total + 1;
        if (locked !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL pre_timeout_locked: got %0b required 1", locked);
        end
        // Last rise registers 3 cycles after it is driven; cnt reaches
        // TIMEOUT 20 cycles later, so sig_lost appears 23 cycles after it.
        repeat (17) @(posedge clk_in);
        #1;
        total = total + 1;
        if (sig_lost !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL early_sig_lost: got %0b required 0", sig_lost);
        end
        @(posedge clk_in);
        #1;
        total = total + 1;
        if ({sig_lost, locked, duty_ok} !== 3'b100) begin
            bad = bad + 1;
            $display("FAIL timeout_flags: got s=%0b l=%0b d=%0b required s=1 l=0 d=0", sig_lost, locked, duty_ok);
        end
        total = total + 1;
        if (period !== W'(5) || high_time !== W'(3)) begin
            bad = bad + 1;
            $display("FAIL timeout_hold: got p=%0d h=%0d required p=5 h=3", period, high_time);
        end
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL timeout_outstanding: got %0d required 0", sb.size());
        end
        model_clear();
        drive_period(3, 2);
        total = total + 1;
        if (sig_lost !== 1'b0 || period !== W'(5)) begin
            bad = bad + 1;
            $display("FAIL relock_clear: got s=%0b p=%0d required s=0 p=5", sig_lost, period);
        end
        finish_check("timeout");
    endtask

    task automatic test_reset_mid_high();
        int v0;
        apply_reset();
        repeat (3) drive_period(4, 4);
        rise_edge(4, 4);
        repeat (6) @(posedge clk_in);
        #1;
        total = total + 1;
        if (period !== W'(8) || high_time !== W'(4)) begin
            bad = bad + 1;
            $display("FAIL pre_reset_meas: got p=%0d h=%0d required p=8 h=4", period, high_time);
        end
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL pre_reset_outstanding: got %0d required 0", sb.size());
        end
        #2 rst_n = 1'b0;
        #1;
        total = total + 1;
        if ({period, high_time, meas_valid, duty_ok, locked, sig_lost} !== '0) begin
            bad = bad + 1;
            $display("FAIL async_reset: got p=%0d h=%0d v=%0b d=%0b l=%0b s=%0b, required all 0",
                     period, high_time, meas_valid, duty_ok, locked, sig_lost);
        end
        model_clear();
        sig_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #3 rst_n = 1'b1;
        v0 = n_valid;
        drive_period(4, 4);
        total = total + 1;
        if (n_valid != v0) begin
            bad = bad + 1;
            $display("FAIL valid_after_first_rise: got %0d pulses required 0", n_valid - v0);
        end
        repeat (2) drive_period(4, 4);
        finish_check("reset_mid_high");
        total = total + 1;
        if (n_valid != v0 + 2) begin
            bad = bad + 1;
            $display("FAIL post_reset_valids: got %0d required 2", n_valid - v0);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        sig_in = 1'b0;
        test_reset();
        test_div3();
        test_div8();
        test_toggle();
        test_ratio_change();
        test_timeout();
        test_reset_mid_high();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
